wb_stage: RTL

- Write-back end of the pipeline. It drives the write port of the ID-stage register file: write_data, write_register and RegWrite, with the file writing at posedge clk.
- Holds the MEM/WB pipeline register, with stall and flush control.
- Selects the ALU result or the load data, and aligns, sign-extends or zero-extends sub-word loads.
- Counts retired instructions.

---
 rtl/wb_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: write-back end of the pipeline. Holds the MEM/WB register, picks ALU or
//   load data, aligns and extends sub-word loads, drives the register-file write port.
// Latency: one cycle from mem_* to WB outputs. Backpressure: stall holds the stage,
//   flush bubbles it (flush wins); an instruction is counted once, when it leaves WB.
// Ports: clk/reset (async, active-high); stall/flush control; mem_* MEM-stage inputs;
//   write_data/write_register/RegWrite to the register file; misaligned flag;
//   retired_count = instructions that have left WB (wraps modulo 2^RETIRE_W).
module wb_stage #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                mem_valid,
  input  logic                mem_RegWrite,
  input  logic                mem_MemtoReg,
  input  logic [2:0]          mem_load_type,
  input  logic [4:0]          mem_write_register,
  input  logic [31:0]         mem_alu_result,
  input  logic [31:0]         mem_read_data,
  output logic [31:0]         write_data,
  output logic [4:0]          write_register,
  output logic                RegWrite,
  output logic                misaligned,
  output logic [RETIRE_W-1:0] retired_count
);

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic                valid_q,     valid_d;
  logic                regwrite_q,  regwrite_d;
  logic                memtoreg_q,  memtoreg_d;
  logic [2:0]          load_type_q, load_type_d;
  logic [4:0]          wr_reg_q,    wr_reg_d;
  logic [31:0]         alu_q,       alu_d;
  logic [31:0]         read_q,      read_d;
  logic [RETIRE_W-1:0] retired_q,   retired_d;

  logic        retire;
  logic [1:0]  off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_value;
  logic        is_half;
  logic        is_word;

  // Stage register next state: flush only kills valid, the payload is then don't-care
  // and is simply held.
  always_comb begin
    valid_d     = valid_q;
    regwrite_d  = regwrite_q;
    memtoreg_d  = memtoreg_q;
    load_type_d = load_type_q;
    wr_reg_d    = wr_reg_q;
    alu_d       = alu_q;
    read_d      = read_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d     = mem_valid;
      regwrite_d  = mem_RegWrite;
      memtoreg_d  = mem_MemtoReg;
      load_type_d = mem_load_type;
      wr_reg_d    = mem_write_register;
      alu_d       = mem_alu_result;
      read_d      = mem_read_data;
    end
  end

  // The occupant leaves WB when the stage advances or is flushed.
  assign retire    = valid_q & (flush | ~stall);
  assign retired_d = retired_q + RETIRE_W'(retire);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      load_type_q <= 3'b000;
      wr_reg_q    <= 5'd0;
      alu_q       <= 32'd0;
      read_q      <= 32'd0;
      retired_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      load_type_q <= load_type_d;
      wr_reg_q    <= wr_reg_d;
      alu_q       <= alu_d;
      read_q      <= read_d;
      retired_q   <= retired_d;
    end
  end

  // Little-endian lane select; the load address is the ALU result.
  assign off = alu_q[1:0];

  always_comb begin
    byte_sel = read_q[7:0];
    case (off)
      2'd0: byte_sel = read_q[7:0];
      2'd1: byte_sel = read_q[15:8];
      2'd2: byte_sel = read_q[23:16];
      2'd3: byte_sel = read_q[31:24];
      default: byte_sel = read_q[7:0];
    endcase
  end

  assign half_sel = off[1] ? read_q[31:16] : read_q[15:0];

  // Unlisted load_type encodings behave as lw.
  always_comb begin
    load_value = read_q;
    case (load_type_q)
      LT_LB:   load_value = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  load_value = {24'd0, byte_sel};
      LT_LH:   load_value = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  load_value = {16'd0, half_sel};
      default: load_value = read_q;
    endcase
  end

  assign is_half = (load_type_q == LT_LH) | (load_type_q == LT_LHU);
  assign is_word = ~(is_half | (load_type_q == LT_LB) | (load_type_q == LT_LBU));

  assign write_register = wr_reg_q;
  assign write_data     = memtoreg_q ? load_value : alu_q;
  // x0 is hard-wired to zero, so a write to it is dropped here.
  assign RegWrite       = valid_q & regwrite_q & (wr_reg_q != 5'd0);
  // Misaligned accesses still write the lane-selected value; no trap from this stage.
  assign misaligned     = valid_q & memtoreg_q &
                          ((is_half & off[0]) | (is_word & (off != 2'd0)));
  assign retired_count  = retired_q;

endmodule
